// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-hazard unit between ID and EXE. It tracks the
// destination tags of in-flight instructions in a shift register with one
// entry per downstream stage. For each ID source operand it picks a bypass
// source or requests a stall. Stalls and flushes insert bubbles, and a
// saturating counter records the number of stall cycles.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   id_valid_i   ID holds a real instruction
//   id_rs_i      NSRC source indices, operand j at [j*REG_W +: REG_W]
//   id_rs_use_i  per-operand read enable
//   id_wr_i      destination index of the ID instruction
//   id_we_i      ID instruction writes id_wr_i
//   id_load_i    ID instruction is a load
//   flush_i      squash the ID instruction
//   stall_o      hold PC/IF/ID and insert a bubble into EXE
//   fwd_sel_o    per operand: 0 = regfile, k = bypass from stage k
//   stall_cnt_o  saturating count of stall cycles
//
// Build option: define HAZARD_FORWARD_EN to enable bypassing. Without it the
// unit runs interlock-only: any match stalls and fwd_sel_o stays 0.

module hazard_scoreboard #(
   parameter int REG_W    = 5,
   parameter int NSRC     = 2,
   parameter int STAGES   = 3,
   parameter int LOAD_RDY = 2,
   parameter int CNT_W    = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              id_valid_i,
   input  logic [NSRC*REG_W-1:0]             id_rs_i,
   input  logic [NSRC-1:0]                   id_rs_use_i,
   input  logic [REG_W-1:0]                  id_wr_i,
   input  logic                              id_we_i,
   input  logic                              id_load_i,
   input  logic                              flush_i,
   output logic                              stall_o,
   output logic [NSRC*$clog2(STAGES+1)-1:0] fwd_sel_o,
   output logic [CNT_W-1:0]                  stall_cnt_o
);

   localparam int SEL_W = $clog2(STAGES+1);

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   // Entry k tracks the instruction currently in stage k (1 = EXE).
   logic [STAGES:1]            v_q,  v_d;
   logic [STAGES:1]            we_q, we_d;
   logic [STAGES:1]            ld_q, ld_d;
   logic [STAGES:1][REG_W-1:0] wr_q, wr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   logic [NSRC-1:0]            req;
   logic [NSRC*SEL_W-1:0]      sel;
   logic                       issue;

   // Per operand, scan from the oldest entry to the youngest so that the
   // youngest match is the one that remains.
   always_comb begin
      logic             hit;
      logic             rdy;
      int               wk;
      logic [REG_W-1:0] rs;
      req = '0;
      sel = '0;
      for (int j = 0; j < NSRC; j++) begin
         rs  = id_rs_i[j*REG_W +: REG_W];
         hit = 1'b0;
         rdy = 1'b0;
         wk  = 0;
         for (int k = STAGES; k >= 1; k--) begin
            if (v_q[k] && we_q[k] && (wr_q[k] == rs) && (rs != '0)) begin
               hit = 1'b1;
               wk  = k;
               rdy = !ld_q[k] || (k >= LOAD_RDY);
            end
         end
         if (id_valid_i && id_rs_use_i[j] && hit) begin
            // Interlock-only builds treat every winner as not ready.
            if (FWD_EN && rdy) begin
               sel[j*SEL_W +: SEL_W] = SEL_W'(wk);
            end else begin
               req[j] = 1'b1;
            end
         end
      end
   end

   assign stall_o   = rst_i && !flush_i && (|req);
   assign fwd_sel_o = (rst_i && !stall_o) ? sel : '0;
   assign issue     = id_valid_i && !stall_o && !flush_i;

   // The tracker never freezes: entries drain every cycle and a stall or
   // flush only replaces the new entry 1 with a bubble.
   always_comb begin
      v_d  = v_q;
      we_d = we_q;
      ld_d = ld_q;
      wr_d = wr_q;
      for (int k = STAGES; k >= 2; k--) begin
         v_d[k]  = v_q[k-1];
         we_d[k] = we_q[k-1];
         ld_d[k] = ld_q[k-1];
         wr_d[k] = wr_q[k-1];
      end
      v_d[1]  = issue;
      we_d[1] = id_we_i;
      ld_d[1] = id_load_i;
      wr_d[1] = id_wr_i;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall_o && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         v_q   <= '0;
         we_q  <= '0;
         ld_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         v_q   <= v_d;
         we_q  <= we_d;
         ld_q  <= ld_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector bench for hazard_scoreboard.
// Expected values cover both the bypass and the interlock-only builds.

module tb_hazard_scoreboard;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       vld;
   logic [9:0] rs;
   logic [1:0] use_v;
   logic [4:0] wr;
   logic       we;
   logic       ld;
   logic       fl;
   logic       stall;
   logic [3:0] fsel;
   logic [2:0] cnt;

   hazard_scoreboard #(.CNT_W(3)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .id_valid_i  (vld),
      .id_rs_i     (rs),
      .id_rs_use_i (use_v),
      .id_wr_i     (wr),
      .id_we_i     (we),
      .id_load_i   (ld),
      .flush_i     (fl),
      .stall_o     (stall),
      .fwd_sel_o   (fsel),
      .stall_cnt_o (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit   rst, vld;
      int   rs0, rs1, u, wr;
      bit   we, ld, fl;
      bit   fs;
      int   fsel, fc;
      bit   is;
      int   ic;
      bit   cc;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic add(input bit r, input bit v, input int a, input int b,
                      input int u, input int w, input bit e, input bit l,
                      input bit f, input bit fs, input int fsl, input int fc,
                      input bit is, input int ic, input bit cc);
      vec_t x;
      x.rst = r; x.vld = v; x.rs0 = a; x.rs1 = b; x.u = u; x.wr = w;
      x.we = e; x.ld = l; x.fl = f; x.fs = fs; x.fsel = fsl; x.fc = fc;
      x.is = is; x.ic = ic; x.cc = cc;
      tbl.push_back(x);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      rst   = x.rst;
      vld   = x.vld;
      rs    = {5'(x.rs1), 5'(x.rs0)};
      use_v = 2'(x.u);
      wr    = 5'(x.wr);
      we    = x.we;
      ld    = x.ld;
      fl    = x.fl;
   endtask

   initial begin
      vec_t z;
      int   ns;
      bit   es;
      int   es_sel;
      int   ec;

      rst = 1'b0; vld = 1'b0; rs = '0; use_v = '0;
      wr = '0; we = 1'b0; ld = 1'b0; fl = 1'b0;

      // reset with a pending read
      add(0,1,3,0,1,0,0,0,0, 0,0,0, 0,0, 0);
      add(0,1,3,0,1,0,0,0,0, 0,0,0, 0,0, 1);
      // ALU producer x5, then four reads of x5
      add(1,1,0,0,0,5,1,0,0, 0,0,0, 0,0, 1);
      add(1,1,5,0,1,0,0,0,0, 0,1,0, 1,0, 1);
      add(1,1,5,0,1,0,0,0,0, 0,2,0, 1,1, 1);
      add(1,1,5,0,1,0,0,0,0, 0,3,0, 1,2, 1);
      add(1,1,5,0,1,0,0,0,0, 0,0,0, 0,3, 1);
      add(0,0,0,0,0,0,0,0,0, 0,0,0, 0,3, 1);
      // load-use on operand 1
      add(1,1,0,0,0,7,1,1,0, 0,0,0, 0,0, 1);
      add(1,1,0,7,2,0,0,0,0, 1,0,0, 1,0, 1);
      add(1,1,0,7,2,0,0,0,0, 0,8,1, 1,1, 1);
      add(1,1,0,7,2,0,0,0,0, 0,12,1, 1,2, 1);
      add(1,1,0,7,2,0,0,0,0, 0,0,1, 0,3, 1);
      add(0,0,0,0,0,0,0,0,0, 0,0,1, 0,3, 1);
      // load, independent, dependent
      add(1,1,0,0,0,7,1,1,0, 0,0,0, 0,0, 1);
      add(1,1,0,0,0,1,1,0,0, 0,0,0, 0,0, 1);
      add(1,1,7,0,1,0,0,0,0, 0,2,0, 1,0, 1);
      add(1,0,0,0,0,0,0,0,0, 0,0,0, 0,1, 1);
      add(0,0,0,0,0,0,0,0,0, 0,0,0, 0,1, 1);
      // youngest match wins, x0 never a hazard
      add(1,1,0,0,0,9,1,0,0, 0,0,0, 0,0, 1);
      add(1,1,0,0,0,1,1,0,0, 0,0,0, 0,0, 1);
      add(1,1,0,0,0,9,1,0,0, 0,0,0, 0,0, 1);
      add(1,1,9,0,1,0,0,0,0, 0,1,0, 1,0, 1);
      add(1,1,0,0,0,0,1,0,0, 0,0,0, 0,1, 1);
      add(1,1,0,0,3,0,0,0,0, 0,0,0, 0,1, 1);
      add(0,0,0,0,0,0,0,0,0, 0,0,0, 0,1, 1);
      // flush beats stall, flushed slot is a bubble
      add(1,1,0,0,0,4,1,1,0, 0,0,0, 0,0, 1);
      add(1,1,4,0,1,6,1,0,1, 0,0,0, 0,0, 1);
      add(1,1,6,0,1,0,0,0,0, 0,0,0, 0,0, 1);
      // reset in the middle of a stall
      add(1,1,0,0,0,5,1,1,0, 0,0,0, 0,0, 1);
      add(1,1,5,0,1,0,0,0,0, 1,0,0, 1,0, 1);
      add(0,1,5,0,1,0,0,0,0, 0,0,1, 0,1, 1);
      add(1,1,5,0,1,0,0,0,0, 0,0,0, 0,0, 1);

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("row%0d stall", i), int'(stall),
             FWD ? int'(tbl[i].fs) : int'(tbl[i].is));
         chk($sformatf("row%0d fwd_sel", i), int'(fsel),
             FWD ? tbl[i].fsel : 0);
         if (tbl[i].cc) begin
            chk($sformatf("row%0d stall_cnt", i), int'(cnt),
                FWD ? tbl[i].fc : tbl[i].ic);
         end
      end

      // saturation: repeated load x7 that also reads x7
      z = '{rst:0, vld:0, rs0:0, rs1:0, u:0, wr:0, we:0, ld:0, fl:0,
            fs:0, fsel:0, fc:0, is:0, ic:0, cc:0};
      @(negedge clk);
      drive(z);
      z.rst = 1; z.vld = 1; z.rs0 = 7; z.u = 1;
      z.wr = 7; z.we = 1; z.ld = 1;
      ns = 0;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         drive(z);
         #1;
         es     = FWD ? (i % 2 == 0) : (i % 4 != 1);
         es_sel = (FWD && (i % 2 == 1) && (i > 1)) ? 2 : 0;
         ec     = (ns > 7) ? 7 : ns;
         chk($sformatf("sat%0d stall", i), int'(stall), int'(es));
         chk($sformatf("sat%0d fwd_sel", i), int'(fsel), es_sel);
         chk($sformatf("sat%0d stall_cnt", i), int'(cnt), ec);
         if (es) ns++;
      end
      @(negedge clk);
      chk("sat final stall_cnt", int'(cnt), 7);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
